// File: rtl/lap_pkg.sv
// Shared types and default timing for the stopwatch lap controller.
package lap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUNNING,
      ST_HOLD,
      ST_STOPPED,
      ST_REVIEW
   } lap_state_t;

   localparam int LAP_PTR_W           = 2;
   localparam int DEF_LAP_DEPTH       = 1 << LAP_PTR_W;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_HOLD_CYCLES     = 10000000;
   localparam int DEF_WIDTH           = 16;

endpackage

// File: rtl/lap_controller_if.sv
// Buttons, live time value and display-side outputs of the lap controller.
interface lap_controller_if
   import lap_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int LAP_DEPTH = DEF_LAP_DEPTH
);
   localparam int CNT_W = $clog2(LAP_DEPTH) + 1;

   logic             btnStart;
   logic             btnLap;
   logic [WIDTH-1:0] liveValue;
   logic             run;
   logic             clear;
   logic [WIDTH-1:0] dispValue;
   logic [CNT_W-1:0] lapCount;
   logic             holdActive;

   modport master (
      output btnStart, btnLap, liveValue,
      input  run, clear, dispValue, lapCount, holdActive
   );

   modport slave (
      input  btnStart, btnLap, liveValue,
      output run, clear, dispValue, lapCount, holdActive
   );

endinterface

// File: rtl/button_debounce.sv
// Raw pushbutton -> synchronised, debounced level plus a one-cycle press pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_q;
   logic [CNT_W-1:0] stable_cnt;

   // two-flop synchroniser for the asynchronous button
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // down-counter: level flips only after DEBOUNCE_CYCLES differing samples in a row
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level      <= 1'b0;
         stable_cnt <= CNT_LOAD;
      end else if (sync_2 == level) begin
         stable_cnt <= CNT_LOAD;
      end else if (stable_cnt == '0) begin
         level      <= sync_2;
         stable_cnt <= CNT_LOAD;
      end else begin
         stable_cnt <= stable_cnt - CNT_W'(1);
      end
   end

   // rising edge of the debounced level; releases produce nothing
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_q <= level;
         press   <= level & ~level_q;
      end
   end

endmodule

// File: rtl/lap_controller.sv
// Stopwatch run/lap sequencer: run gating, counter clear, lap capture and replay.
//
// state      | meaning
// ST_IDLE    | stopped at zero, display live
// ST_RUNNING | counting, display live
// ST_HOLD    | counting, display frozen on the last captured lap
// ST_STOPPED | paused, display live, laps kept
// ST_REVIEW  | paused, stepping through stored laps oldest to newest
module lap_controller
   import lap_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int LAP_DEPTH       = DEF_LAP_DEPTH,
   parameter int WIDTH           = DEF_WIDTH
) (
   input  logic          clock,
   input  logic          reset,
   lap_controller_if.slave bus
);
   localparam int                PTR_W     = $clog2(LAP_DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LAP_DEPTH);

   lap_state_t        state, state_nxt;
   logic              start_press, lap_press, lap_evt;
   logic              start_level, lap_level;
   logic [1:0]        unused_levels;
   logic [WIDTH-1:0]  lap_mem [LAP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [PTR_W-1:0]  oldest_ptr, newest_ptr, rd_ptr_inc;
   logic [CNT_W-1:0]  lap_cnt, lap_cnt_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              capture, flush, clear_nxt;
   logic              run_q, clear_q, hold_q;
   logic [WIDTH-1:0]  disp_q, disp_nxt;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clock (clock),
      .reset (reset),
      .raw   (bus.btnStart),
      .level (start_level),
      .press (start_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clock (clock),
      .reset (reset),
      .raw   (bus.btnLap),
      .level (lap_level),
      .press (lap_press)
   );

   assign unused_levels = {start_level, lap_level};

   // start wins a same-cycle collision
   assign lap_evt    = lap_press & ~start_press;
   assign oldest_ptr = wr_ptr - lap_cnt[PTR_W-1:0];
   assign newest_ptr = wr_ptr - PTR_W'(1);
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);

   // next state, buffer bookkeeping and next output values
   always_comb begin
      state_nxt    = state;
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      lap_cnt_nxt  = lap_cnt;
      hold_cnt_nxt = hold_cnt;
      capture      = 1'b0;
      flush        = 1'b0;
      clear_nxt    = 1'b0;
      disp_nxt     = bus.liveValue;
      case (state)
         ST_IDLE: begin
            if (start_press) state_nxt = ST_RUNNING;
            else if (lap_evt) begin
               clear_nxt = 1'b1;
               flush     = 1'b1;
            end
         end
         ST_RUNNING: begin
            if (start_press) state_nxt = ST_STOPPED;
            else if (lap_evt) begin
               capture   = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (start_press) state_nxt = ST_STOPPED;
            else if (lap_evt) capture = 1'b1;
            else if (hold_cnt == '0) state_nxt = ST_RUNNING;
            else begin
               hold_cnt_nxt = hold_cnt - HOLD_W'(1);
               disp_nxt     = disp_q;
            end
         end
         ST_STOPPED: begin
            if (start_press) state_nxt = ST_RUNNING;
            else if (lap_evt) begin
               if (lap_cnt == '0) begin
                  clear_nxt = 1'b1;
                  flush     = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt  = ST_REVIEW;
                  rd_ptr_nxt = oldest_ptr;
                  disp_nxt   = lap_mem[oldest_ptr];
               end
            end
         end
         ST_REVIEW: begin
            if (start_press) state_nxt = ST_RUNNING;
            else if (lap_evt) begin
               if (rd_ptr == newest_ptr) begin
                  clear_nxt = 1'b1;
                  flush     = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  rd_ptr_nxt = rd_ptr_inc;
                  disp_nxt   = lap_mem[rd_ptr_inc];
               end
            end else begin
               disp_nxt = lap_mem[rd_ptr];
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (capture) begin
         wr_ptr_nxt   = wr_ptr + PTR_W'(1);
         hold_cnt_nxt = HOLD_LOAD;
         disp_nxt     = bus.liveValue;
         if (lap_cnt != CNT_FULL) lap_cnt_nxt = lap_cnt + CNT_W'(1);
      end
      if (flush) begin
         wr_ptr_nxt  = '0;
         rd_ptr_nxt  = '0;
         lap_cnt_nxt = '0;
      end
   end

   // state register, pointers, hold timer and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lap_cnt  <= '0;
         hold_cnt <= '0;
         run_q    <= 1'b0;
         clear_q  <= 1'b0;
         hold_q   <= 1'b0;
         disp_q   <= '0;
      end else begin
         state    <= state_nxt;
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         lap_cnt  <= lap_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
         run_q    <= (state_nxt == ST_RUNNING) || (state_nxt == ST_HOLD);
         clear_q  <= clear_nxt;
         hold_q   <= (state_nxt == ST_HOLD) || (state_nxt == ST_REVIEW);
         disp_q   <= disp_nxt;
      end
   end

   // lap storage; contents are meaningless once lap_cnt is zero, so no reset
   always_ff @(posedge clock) begin
      if (capture) lap_mem[wr_ptr] <= bus.liveValue;
   end

   assign bus.run        = run_q;
   assign bus.clear      = clear_q;
   assign bus.holdActive = hold_q;
   assign bus.dispValue  = disp_q;
   assign bus.lapCount   = lap_cnt;

endmodule
